// File: rtl/mem_wb_stage_if.sv
// Memory->writeback boundary bundle: memory-stage inputs, dbus status, commit record.
// No storage of its own; timing is set by the stage that owns the slave modport.
// stall/req_mask flow back to the memory stage and the dbus driver.
interface mem_wb_stage_if;
    logic        in_valid;
    logic        in_mem;
    logic [63:0] in_pc;
    logic [63:0] in_result;
    logic [4:0]  in_dst;
    logic        in_wen;
    logic        flush;
    logic        addr_ok;
    logic        data_ok;
    logic        req_mask;
    logic        stall;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [63:0] out_result;
    logic [4:0]  out_dst;
    logic        out_wen;
    logic        error;

    // The pipeline register itself.
    modport slave (
        input  in_valid, in_mem, in_pc, in_result, in_dst, in_wen,
        input  flush, addr_ok, data_ok,
        output req_mask, stall,
        output out_valid, out_pc, out_result, out_dst, out_wen, error
    );

    // The memory stage / dbus side that feeds it and consumes the commit.
    modport master (
        output in_valid, in_mem, in_pc, in_result, in_dst, in_wen,
        output flush, addr_ok, data_ok,
        input  req_mask, stall,
        input  out_valid, out_pc, out_result, out_dst, out_wen, error
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory->writeback register; holds the pipeline until the dbus load/store completes.
// Latency: 1 cycle for ALU ops and same-cycle dbus completion, else commit on the data_ok edge.
// Backpressure: stall=1 freezes upstream while waiting; req_mask=1 once the address is accepted.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           reset,
    mem_wb_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ADDR = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t state;
    state_t state_n;
    logic   killed;
    logic   killed_n;
    logic   mem_op;
    logic   commit;

    // Next-state, stall and request-mask decode from the current state and bus status.
    always_comb begin
        state_n      = state;
        killed_n     = killed;
        bus.stall    = 1'b0;
        bus.req_mask = 1'b0;
        mem_op       = bus.in_valid & bus.in_mem;
        case (state)
            WAIT_DATA: begin
                // Address already accepted: the bus op must drain even if flushed.
                bus.req_mask = 1'b1;
                bus.stall    = ~bus.data_ok;
                if (bus.data_ok) begin
                    state_n  = IDLE;
                    killed_n = 1'b0;
                end else if (bus.flush) begin
                    killed_n = 1'b1;
                end
            end
            default: begin
                // IDLE and WAIT_ADDR behave the same: nothing outstanding on the bus yet.
                killed_n = 1'b0;
                state_n  = IDLE;
                if (mem_op) begin
                    if (bus.addr_ok && bus.data_ok) begin
                        state_n = IDLE;
                    end else if (bus.addr_ok) begin
                        // Accepted even when flushed; remember to discard the result.
                        state_n   = WAIT_DATA;
                        bus.stall = 1'b1;
                        killed_n  = bus.flush;
                    end else if (!bus.flush) begin
                        state_n   = WAIT_ADDR;
                        bus.stall = 1'b1;
                    end
                end
            end
        endcase
        commit = bus.in_valid & ~bus.stall & ~bus.flush
               & ~((state == WAIT_DATA) & killed);
    end

    // Control state: FSM and the kill flag for a flushed in-flight bus op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            killed <= 1'b0;
        end else begin
            state  <= state_n;
            killed <= killed_n;
        end
    end

    // Commit record register; data fields only load on a real commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.out_valid  <= 1'b0;
            bus.out_pc     <= 64'd0;
            bus.out_result <= 64'd0;
            bus.out_dst    <= 5'd0;
            bus.out_wen    <= 1'b0;
        end else begin
            bus.out_valid <= commit;
            bus.out_wen   <= commit & bus.in_wen & (bus.in_dst != 5'd0);
            if (commit) begin
                bus.out_pc     <= bus.in_pc;
                bus.out_result <= bus.in_result;
                bus.out_dst    <= bus.in_dst;
            end
        end
    end

`ifdef MEMWB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] wait_cnt;
    logic [15:0] wait_inc;
    logic        entering_wait;

    assign entering_wait = (state_n != IDLE) && (state_n != state);
    assign wait_inc      = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;

    // Watchdog: count cycles spent in a wait state and latch error at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= 16'd0;
            bus.error <= 1'b0;
        end else if (entering_wait) begin
            wait_cnt <= 16'd0;
        end else if (state != IDLE) begin
            wait_cnt <= wait_inc;
            if (wait_inc >= TIMEOUT_LIMIT) begin
                bus.error <= 1'b1;
            end
        end
    end
`else
    assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: cycle table with scoreboard plus reset/watchdog sequences.
// Inputs change 1 time unit after the rising edge; comb outputs sampled on the falling edge.
// Registered outputs are compared 1 time unit after the edge that captures them.
module tb_mem_wb_stage;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage_if bus();

    mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef MEMWB_TIMEOUT_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct {
        logic        v;
        logic        m;
        logic [63:0] pc;
        logic [63:0] res;
        logic [4:0]  dst;
        logic        wen;
        logic        fl;
        logic        ao;
        logic        dk;
        logic        e_stall;
        logic        e_mask;
        logic        e_ov;
        logic        e_wen;
    } vec_t;

    typedef struct {
        logic        v;
        logic [63:0] pc;
        logic [63:0] res;
        logic [4:0]  dst;
        logic        wen;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic v, input logic m, input logic [63:0] pc,
                                input logic [63:0] res, input logic [4:0] dst, input logic wen,
                                input logic fl, input logic ao, input logic dk,
                                input logic e_stall, input logic e_mask,
                                input logic e_ov, input logic e_wen);
        vec_t r;
        r.v = v; r.m = m; r.pc = pc; r.res = res; r.dst = dst; r.wen = wen;
        r.fl = fl; r.ao = ao; r.dk = dk;
        r.e_stall = e_stall; r.e_mask = e_mask; r.e_ov = e_ov; r.e_wen = e_wen;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        bus.in_valid  = r.v;
        bus.in_mem    = r.m;
        bus.in_pc     = r.pc;
        bus.in_result = r.res;
        bus.in_dst    = r.dst;
        bus.in_wen    = r.wen;
        bus.flush     = r.fl;
        bus.addr_ok   = r.ao;
        bus.data_ok   = r.dk;
    endtask

    initial begin
        vec_t idle_v;
        exp_t e;
        idle_v = mk(0,0,64'h0,64'h0,5'd0,0, 0,0,0, 0,0,0,0);

        //        v m pc                  res                  dst  wen fl ao dk  stall mask ov wen
        // ALU op commits next cycle
        vecs.push_back(mk(1,0,64'h8000_0000,64'h5,               5'd3, 1, 0,0,0, 0,0,1,1));
        // bubble, and mem flag without valid
        vecs.push_back(mk(0,0,64'h0,        64'h0,               5'd0, 0, 0,0,0, 0,0,0,0));
        vecs.push_back(mk(0,1,64'h0,        64'h0,               5'd4, 1, 0,0,0, 0,0,0,0));
        // LD with addr_ok and data_ok in the same cycle
        vecs.push_back(mk(1,1,64'h8000_0004,64'hdead_beef,       5'd5, 1, 0,1,1, 0,0,1,1));
        // SD: addr_ok cycle 0, data_ok cycle 3, result sampled live on data_ok
        vecs.push_back(mk(1,1,64'h8000_0008,64'haaaa,            5'd7, 0, 0,1,0, 1,0,0,0));
        vecs.push_back(mk(1,1,64'h8000_0008,64'haaaa,            5'd7, 0, 0,0,0, 1,1,0,0));
        vecs.push_back(mk(1,1,64'h8000_0008,64'haaaa,            5'd7, 0, 0,0,0, 1,1,0,0));
        vecs.push_back(mk(1,1,64'h8000_0008,64'h1234,            5'd7, 0, 0,0,1, 0,1,1,0));
        // ADDI x0: valid commit, write suppressed
        vecs.push_back(mk(1,0,64'h8000_000c,64'h77,              5'd0, 1, 0,0,0, 0,0,1,0));
        // LW: two address waits, accept, flush in WAIT_DATA, drain 2 cycles later
        vecs.push_back(mk(1,1,64'h8000_0010,64'h0,               5'd9, 1, 0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,1,64'h8000_0010,64'h0,               5'd9, 1, 0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,1,64'h8000_0010,64'h0,               5'd9, 1, 0,1,0, 1,0,0,0));
        vecs.push_back(mk(1,1,64'h8000_0010,64'h0,               5'd9, 1, 1,0,0, 1,1,0,0));
        vecs.push_back(mk(1,1,64'h8000_0010,64'h0,               5'd9, 1, 0,0,0, 1,1,0,0));
        vecs.push_back(mk(1,1,64'h8000_0010,64'h55,              5'd9, 1, 0,0,1, 0,1,0,0));
        // back in IDLE: ALU commits, no mask
        vecs.push_back(mk(1,0,64'h8000_0014,64'h99,              5'd10,1, 0,0,0, 0,0,1,1));
        // flush of an ALU op in IDLE
        vecs.push_back(mk(1,0,64'h8000_0018,64'h1,               5'd11,1, 1,0,0, 0,0,0,0));
        // flush in WAIT_ADDR drops the op
        vecs.push_back(mk(1,1,64'h8000_001c,64'h0,               5'd12,1, 0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,1,64'h8000_001c,64'h0,               5'd12,1, 1,0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,64'h8000_0020,64'h22,              5'd13,1, 0,0,0, 0,0,1,1));
        // addr_ok in the flush cycle: drains as killed
        vecs.push_back(mk(1,1,64'h8000_0024,64'h0,               5'd14,1, 1,1,0, 1,0,0,0));
        vecs.push_back(mk(1,1,64'h8000_0024,64'h66,              5'd14,1, 0,0,1, 0,1,0,0));
        vecs.push_back(mk(1,0,64'h8000_0028,64'h33,              5'd15,1, 0,0,0, 0,0,1,1));
        // WAIT_ADDR then addr_ok & data_ok together
        vecs.push_back(mk(1,1,64'h8000_002c,64'h0,               5'd16,1, 0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,1,64'h8000_002c,64'hcafe_f00d,       5'd16,1, 0,1,1, 0,0,1,1));

        // Reset state
        reset = 1'b0;
        drive(idle_v);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset out_valid",  {63'd0, bus.out_valid}, 64'd0);
        check("reset out_pc",     bus.out_pc, 64'd0);
        check("reset out_result", bus.out_result, 64'd0);
        check("reset out_dst",    {59'd0, bus.out_dst}, 64'd0);
        check("reset out_wen",    {63'd0, bus.out_wen}, 64'd0);
        check("reset error",      {63'd0, bus.error}, 64'd0);
        check("reset req_mask",   {63'd0, bus.req_mask}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Table: one row per cycle, expected commit pushed when driven, popped after the edge
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            e.v   = vecs[i].e_ov;
            e.pc  = vecs[i].pc;
            e.res = vecs[i].res;
            e.dst = vecs[i].dst;
            e.wen = vecs[i].e_wen;
            sb.push_back(e);
            @(negedge clk);
            check($sformatf("row%0d stall", i),    {63'd0, bus.stall},    {63'd0, vecs[i].e_stall});
            check($sformatf("row%0d req_mask", i), {63'd0, bus.req_mask}, {63'd0, vecs[i].e_mask});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("row%0d out_valid", i), {63'd0, bus.out_valid}, {63'd0, e.v});
            check($sformatf("row%0d out_wen", i),   {63'd0, bus.out_wen},   {63'd0, e.wen});
            if (e.v) begin
                check($sformatf("row%0d out_pc", i),     bus.out_pc, e.pc);
                check($sformatf("row%0d out_result", i), bus.out_result, e.res);
                check($sformatf("row%0d out_dst", i),    {59'd0, bus.out_dst}, {59'd0, e.dst});
            end
        end

        // Reset mid-transaction: async clear of outputs and FSM
        drive(mk(1,0,64'h8000_0100,64'h11,5'd1,1, 0,0,0, 0,0,0,0));
        @(posedge clk);
        #1;
        check("pre-reset out_valid", {63'd0, bus.out_valid}, 64'd1);
        drive(mk(1,1,64'h8000_0104,64'h0,5'd2,1, 0,1,0, 0,0,0,0));
        @(posedge clk);
        #1;
        drive(mk(1,1,64'h8000_0104,64'h0,5'd2,1, 0,0,0, 0,0,0,0));
        @(negedge clk);
        check("pre-reset req_mask", {63'd0, bus.req_mask}, 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check("async reset out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("async reset out_pc",    bus.out_pc, 64'd0);
        check("async reset req_mask",  {63'd0, bus.req_mask}, 64'd0);
        drive(idle_v);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(mk(1,0,64'h8000_0200,64'h42,5'd6,1, 0,0,0, 0,0,0,0));
        @(negedge clk);
        check("post-reset stall",    {63'd0, bus.stall}, 64'd0);
        check("post-reset req_mask", {63'd0, bus.req_mask}, 64'd0);
        @(posedge clk);
        #1;
        check("post-reset out_valid",  {63'd0, bus.out_valid}, 64'd1);
        check("post-reset out_result", bus.out_result, 64'h42);

        // Watchdog: data_ok withheld for 4 wait cycles
        drive(mk(1,1,64'h8000_0300,64'h0,5'd8,1, 0,1,0, 0,0,0,0));
        @(posedge clk);
        #1;
        drive(mk(1,1,64'h8000_0300,64'h0,5'd8,1, 0,0,0, 0,0,0,0));
        repeat (3) @(posedge clk);
        #1;
        check("error before limit", {63'd0, bus.error}, 64'd0);
        @(posedge clk);
        #1;
        check("error at limit", {63'd0, bus.error}, {63'd0, EXP_ERR});
        drive(mk(1,1,64'h8000_0300,64'h5a,5'd8,1, 0,0,1, 0,0,0,0));
        @(posedge clk);
        #1;
        check("late load commit", {63'd0, bus.out_valid}, 64'd1);
        drive(idle_v);
        @(posedge clk);
        #1;
        check("error sticky", {63'd0, bus.error}, {63'd0, EXP_ERR});
        reset = 1'b0;
        #2;
        check("error cleared by reset", {63'd0, bus.error}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
